// File: rtl/sha256_block_padder.sv
// SHA-256 message padder: streams a NUM_OF_WORDS-word message from synchronous memory as
// padded 512-bit blocks, one 32-bit word per valid/ready handshake.
module sha256_block_padder #(
    parameter int unsigned NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_block_end,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NumBlocks = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam logic [63:0] BitLen    = 64'(NUM_OF_WORDS) * 64'd32;
    localparam logic [15:0] MsgWords  = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LenHiWord = 16'(16 * NumBlocks - 2);
    localparam logic [15:0] LenLoWord = 16'(16 * NumBlocks - 1);
    localparam logic [7:0]  LastBlk   = 8'(NumBlocks - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [7:0]  blk_q, blk_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] blk_buf_q [16];
    logic [31:0] blk_buf_d [16];

    logic [15:0] blk_base;
    logic [3:0]  wr_idx;
    logic [15:0] g;
    logic [31:0] fill_word;

    assign mem_clk  = clk;
    assign mem_we   = 1'b0;
    assign blk_base = {4'b0, blk_q, 4'b0};
    // Read data lags the address by one cycle, so FETCH step f fills slot f-1.
    assign wr_idx   = cnt_q[3:0] - 4'd1;
    assign g        = blk_base + {12'b0, wr_idx};

    always_comb begin
        fill_word = 32'h0;
        if (g < MsgWords) begin
            fill_word = mem_read_data;
        end else if (g == MsgWords) begin
            fill_word = 32'h8000_0000;
        end else if (g == LenHiWord) begin
            fill_word = BitLen[63:32];
        end else if (g == LenLoWord) begin
            fill_word = BitLen[31:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        blk_d         = blk_q;
        cnt_d         = cnt_q;
        blk_buf_d     = blk_buf_q;
        mem_addr      = 16'h0;
        out_valid     = 1'b0;
        out_word      = 32'h0;
        out_block_end = 1'b0;
        out_last      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        // Outputs are forced quiet for the whole reset cycle, not just after the edge.
        if (!reset) begin
            busy = (state_q != StIdle);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        base_d  = message_addr;
                        blk_d   = 8'd0;
                        cnt_d   = 5'd0;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (!cnt_q[4]) begin
                        mem_addr = base_q + blk_base + {12'b0, cnt_q[3:0]};
                    end
                    if (cnt_q != 5'd0) begin
                        blk_buf_d[wr_idx] = fill_word;
                    end
                    if (cnt_q == 5'd16) begin
                        cnt_d   = 5'd0;
                        state_d = StEmit;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                StEmit: begin
                    out_valid     = 1'b1;
                    out_word      = blk_buf_q[cnt_q[3:0]];
                    out_block_end = (cnt_q == 5'd15);
                    out_last      = (cnt_q == 5'd15) && (blk_q == LastBlk);
                    if (out_ready) begin
                        if (cnt_q == 5'd15) begin
                            cnt_d = 5'd0;
                            if (blk_q == LastBlk) begin
                                state_d = StDone;
                            end else begin
                                blk_d   = blk_q + 8'd1;
                                state_d = StFetch;
                            end
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                StDone: begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= 16'h0;
            blk_q   <= 8'd0;
            cnt_q   <= 5'd0;
            for (int i = 0; i < 16; i++) begin
                blk_buf_q[i] <= 32'h0;
            end
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            blk_q     <= blk_d;
            cnt_q     <= cnt_d;
            blk_buf_q <= blk_buf_d;
        end
    end

endmodule

// File: doc/sha256_block_padder.md
SHA256_BLOCK_PADDER -- requirements
Module: sha256_block_padder

Interface
REQ-001 Parameter: NUM_OF_WORDS, default 20, message length in 32-bit words; legal range 1..4000.
REQ-002 Port: clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high reset.
REQ-004 Port: start, input, 1, begin padding the message; sampled only in IDLE.
REQ-005 Port: message_addr, input, 16, word address of message word 0; captured when start is accepted.
REQ-006 Port: mem_clk, output, 1, equals clk.
REQ-007 Port: mem_we, output, 1, tied 0 (read-only client).
REQ-008 Port: mem_addr, output, 16, read address.
REQ-009 Port: mem_read_data, input, 32, synchronous read data, valid the cycle after mem_addr is presented.
REQ-010 Port: out_valid, output, 1, out_word carries a padded-block word.
REQ-011 Port: out_ready, input, 1, consumer accepts out_word when out_valid && out_ready.
REQ-012 Port: out_word, output, 32, padded-block word.
REQ-013 Port: out_block_end, output, 1, out_word is word 15 of a block.
REQ-014 Port: out_last, output, 1, out_word is word 15 of the final block.
REQ-015 Port: busy, output, 1, high in any state other than IDLE.
REQ-016 Port: done, output, 1, one-cycle pulse after the final word is accepted.

Function
REQ-017 Block count: nb = (NUM_OF_WORDS+2)/16 + 1 (integer division); bit length L = 32*NUM_OF_WORDS as a 64-bit value.
REQ-018 Global word g = 16*blk + idx: g < NUM_OF_WORDS -> memory word at message_addr+g; g == NUM_OF_WORDS -> 32'h80000000; g == 16*nb-2 -> L[63:32]; g == 16*nb-1 -> L[31:0]; otherwise 32'h0.
REQ-019 States: IDLE, FETCH, EMIT, DONE.
REQ-020 IDLE: start=1 -> capture message_addr, set blk=0, go to FETCH; start=0 -> stay.
REQ-021 FETCH lasts exactly 17 cycles, indexed f=0..16.
REQ-022 During FETCH, at f<=15, mem_addr = message_addr + 16*blk + f.
REQ-023 During FETCH, at f>=1, buf[f-1] is written with the REQ-018 value for g = 16*blk + f-1, using mem_read_data for memory words.
REQ-024 At FETCH f=16, the next state is EMIT with idx=0.
REQ-025 EMIT: out_valid=1 and out_word=buf[idx]; on each handshake idx increments.
REQ-026 EMIT: out_word, out_block_end and out_last are held stable while out_valid && !out_ready.
REQ-027 EMIT, handshake at idx=15 with blk < nb-1 -> blk+1, go to FETCH.
REQ-028 EMIT, handshake at idx=15 with blk = nb-1 -> go to DONE.
REQ-029 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-030 Latency with out_ready held high: start accepted at cycle 0 -> done=1 at cycle 33*nb+1.
REQ-031 start outside IDLE is ignored.
REQ-032 Address arithmetic wraps modulo 2^16.
REQ-033 NUM_OF_WORDS%16 == 14 or 15: the pad word fills the last block of message data and the length is carried in an extra all-zero-plus-length block.
REQ-034 NUM_OF_WORDS%16 == 0: the extra block begins with 32'h80000000.
REQ-035 out_valid is 0 in every state except EMIT; out_block_end and out_last are 0 whenever out_valid is 0.

Reset
REQ-036 While reset=1: state=IDLE, out_valid=0, out_word=0, out_block_end=0, out_last=0, busy=0, done=0, mem_addr=0, counters=0.
REQ-037 Reset asserted mid-FETCH or mid-EMIT aborts the message; the next start replays from word 0 with no stale buffer contents visible.
REQ-038 Reset has priority over start when both are high.

Verification
REQ-039 NUM=20, mem[a+i]=i, out_ready=1 -> 32 words: 0..19, 32'h80000000, zeros, word30=0, word31=32'h280; out_block_end at words 15 and 31; out_last at word 31; done at cycle 67.
REQ-040 NUM=14 -> 2 blocks: words 0..13, 32'h80000000, 0; block 1 all zero except word15=32'h1C0.
REQ-041 NUM=13 -> 1 block: words 0..12, 32'h80000000, 0, 32'h1A0; done at cycle 34.
REQ-042 NUM=16 -> block 1 word0=32'h80000000, word15=32'h200.
REQ-043 Backpressure: out_ready low for 5 cycles at idx=7 -> out_word held at buf[7] and idx unchanged; done delayed exactly 5 cycles.
REQ-044 Reset pulsed at EMIT idx=3 -> next cycle out_valid=0 and busy=0; a re-start produces a stream identical to REQ-039; start pulses while busy produce no extra done pulse.
